fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer.sv | 119 +++++++++++
 tb/tb_fifo_rd_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops DSIZE-bit FIFO words and emits RATIO-lane beats on a valid/ready stream.
// Optional partial-beat flush after FLUSH_CYCLES idle cycles is enabled by defining FIFO_PACK_FLUSH_EN.
module fifo_rd_packer #(
  parameter int DSIZE        = 8,
  parameter int RATIO        = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  output logic [DSIZE*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int          CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned NL = RATIO - 1;
  localparam int          AW = DSIZE * (RATIO - 1);

  if (RATIO < 2 || RATIO > 16 || (RATIO & (RATIO - 1)) != 0 ||
      FLUSH_CYCLES < 1 || FLUSH_CYCLES > 255) begin : g_cfg_check
    $error("fifo_rd_packer: illegal parameter combination");
  end

  logic                   r_run;
  logic [CW-1:0]          r_cnt;
  logic [AW-1:0]          r_acc;
  logic [DSIZE*RATIO-1:0] r_data;
  logic [RATIO-1:0]       r_keep;
  logic                   r_valid;

  logic w_last;
  logic w_stall;
  logic w_free;
  logic w_flush_now;
  logic w_rinc;

  assign w_last  = (r_cnt == CW'(RATIO - 1));
  assign w_free  = ~r_valid | m_ready;
  assign w_stall = w_last & r_valid & ~m_ready;
  assign w_rinc  = r_run & ~rempty & ~w_stall & ~w_flush_now;

`ifdef FIFO_PACK_FLUSH_EN
  logic [7:0]             r_idle;
  logic [DSIZE*RATIO-1:0] w_flush_data;
  logic [RATIO-1:0]       w_flush_keep;

  assign w_flush_now = (r_idle == 8'(FLUSH_CYCLES)) & (r_cnt != '0) & w_free;

  always_comb begin
    w_flush_data = '0;
    w_flush_keep = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      if (i < 32'(r_cnt)) begin
        w_flush_data[i*DSIZE +: DSIZE] = r_acc[i*DSIZE +: DSIZE];
        w_flush_keep[i]                = 1'b1;
      end
    end
  end

  // Saturates at the threshold so a blocked flush stays pending until the output frees up.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_idle <= '0;
    end else if (w_rinc || (r_cnt == '0) || w_flush_now) begin
      r_idle <= '0;
    end else if (r_idle != 8'(FLUSH_CYCLES)) begin
      r_idle <= r_idle + 8'd1;
    end
  end
`else
  assign w_flush_now = 1'b0;
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_run <= 1'b1;
      // A load below overrides this clear, giving back-to-back beats without a bubble.
      if (r_valid && m_ready) r_valid <= 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
      if (w_flush_now) begin
        r_data  <= w_flush_data;
        r_keep  <= w_flush_keep;
        r_valid <= 1'b1;
        r_cnt   <= '0;
      end else
`endif
      if (w_rinc) begin
        if (w_last) begin
          r_data  <= {rdata, r_acc};
          r_keep  <= '1;
          r_valid <= 1'b1;
          r_cnt   <= '0;
        end else begin
          for (int unsigned i = 0; i < NL; i++) begin
            if (i == 32'(r_cnt)) r_acc[i*DSIZE +: DSIZE] <= rdata;
          end
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign rinc    = w_rinc;
  assign m_data  = r_data;
  assign m_keep  = r_keep;
  assign m_valid = r_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer (DSIZE=8, RATIO=4): a FIFO model feeds words, expected
// beats are queued by the stimulus, and a monitor compares every accepted beat.
module tb_fifo_rd_packer;

  logic        rclk;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;

  fifo_rd_packer #(.DSIZE(8), .RATIO(4), .FLUSH_CYCLES(16)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .m_data (m_data),
    .m_keep (m_keep),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] mem[256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic       gap;
  int         n_checks;
  int         n_fail;

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k);
    beat_t b;
    b.d = d;
    b.k = k;
    exp_q.push_back(b);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wr_ptr   = '0;
    rd_ptr   = '0;
    gap      = 1'b0;
    rempty   = 1'b1;
    rdata    = '0;
    rrst_n   = 1'b0;
    m_ready  = 1'b0;

    fork
      begin : fifo_model
        logic popped;
        forever begin
          @(posedge rclk);
          popped = rinc;
          #2;
          if (popped) rd_ptr = rd_ptr + 8'd1;
          rempty = (rd_ptr == wr_ptr) | gap;
          rdata  = mem[rd_ptr];
        end
      end
      begin : monitor
        logic        pv, pr;
        logic [31:0] pd;
        logic [3:0]  pk;
        beat_t       e;
        pv = 1'b0; pr = 1'b0; pd = '0; pk = '0;
        forever begin
          @(negedge rclk);
          if (!rrst_n) begin
            pv = 1'b0;
          end else begin
            check("rinc_while_empty", {63'd0, rinc & rempty}, 64'd0);
            if (pv && !pr) begin
              check("held_data", {32'd0, m_data}, {32'd0, pd});
              check("held_keep", {60'd0, m_keep}, {60'd0, pk});
            end
            if (m_valid && m_ready) begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h keep %0h, expected no beat", m_data, m_keep);
              end else begin
                e = exp_q.pop_front();
                check("beat_data", {32'd0, m_data}, {32'd0, e.d});
                check("beat_keep", {60'd0, m_keep}, {60'd0, e.k});
              end
            end
            pv = m_valid; pr = m_ready; pd = m_data; pk = m_keep;
          end
        end
      end
      begin : watchdog
        repeat (20000) @(posedge rclk);
        $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    tick(); tick();
    check("reset_rinc",  {63'd0, rinc},    64'd0);
    check("reset_valid", {63'd0, m_valid}, 64'd0);
    check("reset_data",  {32'd0, m_data},  64'd0);
    check("reset_keep",  {60'd0, m_keep},  64'd0);

    // Streaming: words available at release, first edge after release must not pop
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h08070605, 4'hF);
    @(negedge rclk);
    check("run_gate_rinc", {63'd0, rinc}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      check("stream_rinc", {63'd0, rinc}, 64'd1);
    end
    @(negedge rclk);
    check("stream_rinc_end", {63'd0, rinc}, 64'd0);
    repeat (3) tick();

    // Back-pressure: one beat held, three lanes popped, stall with a word still waiting
    m_ready = 1'b0;
    for (int i = 8'h11; i <= 8'h18; i++) push(8'(i));
    expect_beat(32'h14131211, 4'hF);
    expect_beat(32'h18171615, 4'hF);
    repeat (12) tick();
    @(negedge rclk);
    check("stall_rinc",  {63'd0, rinc},    64'd0);
    check("stall_valid", {63'd0, m_valid}, 64'd1);
    check("stall_data",  {32'd0, m_data},  64'h14131211);
    tick();
    m_ready = 1'b1;
    @(negedge rclk);
    check("handshake_pop", {63'd0, rinc}, 64'd1);
    tick();
    @(negedge rclk);
    check("no_bubble_valid", {63'd0, m_valid}, 64'd1);
    check("no_bubble_data",  {32'd0, m_data},  64'h18171615);
    repeat (3) tick();

    // Empty gaps every other cycle
    for (int i = 8'h21; i <= 8'h28; i++) push(8'(i));
    expect_beat(32'h24232221, 4'hF);
    expect_beat(32'h28272625, 4'hF);
    for (int i = 0; i < 24; i++) begin
      gap = ~gap;
      tick();
    end
    gap = 1'b0;
    repeat (4) tick();

    // Reset mid-beat: beat 34333231 pending and lanes 35,36 accumulated, all discarded
    m_ready = 1'b0;
    for (int i = 8'h31; i <= 8'h36; i++) push(8'(i));
    repeat (10) tick();
    check("pre_reset_valid", {63'd0, m_valid}, 64'd1);
    rrst_n = 1'b0;
    #1;
    check("midreset_rinc",  {63'd0, rinc},    64'd0);
    check("midreset_valid", {63'd0, m_valid}, 64'd0);
    check("midreset_data",  {32'd0, m_data},  64'd0);
    check("midreset_keep",  {60'd0, m_keep},  64'd0);
    tick(); tick();
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    for (int i = 8'h41; i <= 8'h44; i++) push(8'(i));
    expect_beat(32'h44434241, 4'hF);
    repeat (10) tick();

`ifdef FIFO_PACK_FLUSH_EN
    // Flush after 16 idle cycles, with a word arriving in the flush cycle itself
    push(8'hAA); push(8'hBB);
    expect_beat(32'h0000BBAA, 4'h3);
    repeat (18) tick();
    push(8'hCC);
    @(negedge rclk);
    check("flush_cycle_rinc",  {63'd0, rinc},    64'd0);
    check("flush_cycle_valid", {63'd0, m_valid}, 64'd0);
    @(negedge rclk);
    check("flush_valid",    {63'd0, m_valid}, 64'd1);
    check("flush_data",     {32'd0, m_data},  64'h0000BBAA);
    check("flush_keep",     {60'd0, m_keep},  64'h3);
    check("post_flush_pop", {63'd0, rinc},    64'd1);
    tick();
    push(8'hDD); push(8'hEE); push(8'hFF);
    expect_beat(32'hFFEEDDCC, 4'hF);
    repeat (10) tick();
`else
    // No flush: partial beat held indefinitely
    push(8'hAA); push(8'hBB);
    expect_beat(32'hDDCCBBAA, 4'hF);
    repeat (100) begin
      @(negedge rclk);
      check("noflush_hold", {63'd0, m_valid}, 64'd0);
    end
    tick();
    push(8'hCC); push(8'hDD);
    repeat (8) tick();
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
